mem_port_arbiter: RTL and testbench

Single-port memory arbiter that shares one synchronous unified instruction/data memory between the fetch stage (read-only) and the mem-access stage (read/write). Sits between `inst_fetch` / `mem_access` and the memory macro. Grants at most one access per cycle, tracks the owner of the outstanding read, and drives per-stage stall signals for the control unit. Supports squashing in-flight fetch data on a flush or mispredict.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_starve_cnt.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and default sizes for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int unsigned c_default_aw           = 16;
    localparam int unsigned c_default_dw           = 16;
    localparam int unsigned c_default_starve_limit = 4;

    // Which requester owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_MA   = 2'd2
    } rsp_owner_t;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
// ============================================================================
// Module   : arb_starve_cnt
// Brief    : Saturating count of consecutive denied fetch cycles; raises
//            force_if once the limit is reached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = c_default_starve_limit
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic if_flush,
    output logic force_if
);

    localparam int unsigned      c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (if_gnt || !if_req || if_flush) begin
            r_cnt <= '0;
        end else if (r_cnt != c_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_if = (r_cnt == c_limit);

endmodule : arb_starve_cnt

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous memory between fetch and mem-access with
//            mem-access priority; optional fetch starvation guard via
//            MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = c_default_aw,
    parameter int unsigned DW = c_default_dw
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = c_default_starve_limit
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          ma_req,
    input  logic          ma_we,
    input  logic [AW-1:0] ma_addr,
    input  logic [DW-1:0] ma_wdata,
    output logic          ma_gnt,
    output logic          ma_rvalid,
    output logic [DW-1:0] ma_rdata,
    output logic          ma_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    rsp_owner_t r_rsp_q;
    logic       w_force_if;
    logic       w_if_gnt;
    logic       w_ma_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (w_if_gnt),
        .if_flush (if_flush),
        .force_if (w_force_if)
    );
`else
    assign w_force_if = 1'b0;
`endif

    // A flushed fetch never wins, so mem-access keeps the port in that cycle.
    assign w_if_gnt = !rst && if_req && !if_flush && (!ma_req || w_force_if);
    assign w_ma_gnt = !rst && ma_req && !w_if_gnt;

    assign if_gnt    = w_if_gnt;
    assign ma_gnt    = w_ma_gnt;
    assign if_stall  = !rst && if_req && !w_if_gnt;
    assign ma_stall  = !rst && ma_req && !w_ma_gnt;

    assign mem_en    = w_if_gnt || w_ma_gnt;
    assign mem_we    = w_ma_gnt && ma_we;
    assign mem_addr  = w_ma_gnt ? ma_addr : if_addr;
    assign mem_wdata = ma_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_q <= RSP_NONE;
        end else if (w_if_gnt) begin
            r_rsp_q <= RSP_IF;
        end else if (w_ma_gnt && !ma_we) begin
            r_rsp_q <= RSP_MA;
        end else begin
            r_rsp_q <= RSP_NONE;
        end
    end

    assign if_rvalid = !rst && (r_rsp_q == RSP_IF) && !if_flush;
    assign ma_rvalid = !rst && (r_rsp_q == RSP_MA);
    assign if_rdata  = mem_rdata;
    assign ma_rdata  = mem_rdata;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int unsigned c_aw = 16;
    localparam int unsigned c_dw = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [c_aw-1:0] if_addr;
    logic            if_flush;
    logic            if_gnt;
    logic            if_rvalid;
    logic [c_dw-1:0] if_rdata;
    logic            if_stall;
    logic            ma_req;
    logic            ma_we;
    logic [c_aw-1:0] ma_addr;
    logic [c_dw-1:0] ma_wdata;
    logic            ma_gnt;
    logic            ma_rvalid;
    logic [c_dw-1:0] ma_rdata;
    logic            ma_stall;
    logic            mem_en;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic [c_dw-1:0] mem_rdata;

    int unsigned r_checks   = 0;
    int unsigned r_failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW (c_aw),
        .DW (c_dw)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .ma_req    (ma_req),
        .ma_we     (ma_we),
        .ma_addr   (ma_addr),
        .ma_wdata  (ma_wdata),
        .ma_gnt    (ma_gnt),
        .ma_rvalid (ma_rvalid),
        .ma_rdata  (ma_rdata),
        .ma_stall  (ma_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = '0;
        if_flush  = 1'b0;
        ma_req    = 1'b1;
        ma_we     = 1'b0;
        ma_addr   = '0;
        ma_wdata  = '0;
        mem_rdata = '0;

        // Reset holds every control output low even with requests present.
        next_cycle();
        sample();
        check("rst_if_gnt",   {31'd0, if_gnt},   32'd0);
        check("rst_ma_gnt",   {31'd0, ma_gnt},   32'd0);
        check("rst_if_stall", {31'd0, if_stall}, 32'd0);
        check("rst_ma_stall", {31'd0, ma_stall}, 32'd0);
        check("rst_mem_en",   {31'd0, mem_en},   32'd0);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);

        next_cycle();
        rst    = 1'b0;
        if_req = 1'b0;
        ma_req = 1'b0;
        sample();
        check("post_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("post_rst_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);

        // Fetch only.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 16'h0010;
        sample();
        check("fetch_if_gnt",   {31'd0, if_gnt},   32'd1);
        check("fetch_mem_en",   {31'd0, mem_en},   32'd1);
        check("fetch_mem_we",   {31'd0, mem_we},   32'd0);
        check("fetch_mem_addr", {16'd0, mem_addr}, 32'h0010);
        check("fetch_if_stall", {31'd0, if_stall}, 32'd0);
        next_cycle();
        if_req    = 1'b0;
        mem_rdata = 16'hA5A5;
        sample();
        check("fetch_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("fetch_if_rdata",  {16'd0, if_rdata},  32'hA5A5);
        check("fetch_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);
        check("fetch_idle_en",   {31'd0, mem_en},    32'd0);

        // Contention: mem-access load beats fetch.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 16'h0020;
        ma_req  = 1'b1;
        ma_we   = 1'b0;
        ma_addr = 16'h0200;
        sample();
        check("cont_ma_gnt",   {31'd0, ma_gnt},   32'd1);
        check("cont_if_gnt",   {31'd0, if_gnt},   32'd0);
        check("cont_if_stall", {31'd0, if_stall}, 32'd1);
        check("cont_ma_stall", {31'd0, ma_stall}, 32'd0);
        check("cont_mem_addr", {16'd0, mem_addr}, 32'h0200);
        next_cycle();
        if_req    = 1'b0;
        ma_req    = 1'b0;
        mem_rdata = 16'h5A5A;
        sample();
        check("cont_ma_rvalid", {31'd0, ma_rvalid}, 32'd1);
        check("cont_ma_rdata",  {16'd0, ma_rdata},  32'h5A5A);
        check("cont_if_rvalid", {31'd0, if_rvalid}, 32'd0);

        // Store: no read data afterwards.
        next_cycle();
        ma_req   = 1'b1;
        ma_we    = 1'b1;
        ma_addr  = 16'h0300;
        ma_wdata = 16'h1234;
        sample();
        check("st_ma_gnt",    {31'd0, ma_gnt},    32'd1);
        check("st_mem_en",    {31'd0, mem_en},    32'd1);
        check("st_mem_we",    {31'd0, mem_we},    32'd1);
        check("st_mem_addr",  {16'd0, mem_addr},  32'h0300);
        check("st_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
        next_cycle();
        ma_req = 1'b0;
        ma_we  = 1'b0;
        sample();
        check("st_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);

        // Flush squashes returning fetch data and blocks the new fetch.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 16'h0040;
        sample();
        check("fl_if_gnt_n", {31'd0, if_gnt}, 32'd1);
        next_cycle();
        if_flush = 1'b1;
        sample();
        check("fl_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("fl_if_gnt",    {31'd0, if_gnt},    32'd0);
        check("fl_if_stall",  {31'd0, if_stall},  32'd1);
        check("fl_mem_en",    {31'd0, mem_en},    32'd0);
        next_cycle();
        if_req = 1'b1;
        ma_req = 1'b1;
        ma_addr = 16'h0400;
        sample();
        check("fl_ma_gnt", {31'd0, ma_gnt}, 32'd1);
        check("fl_if_rv2", {31'd0, if_rvalid}, 32'd0);
        next_cycle();
        if_flush = 1'b0;
        if_req   = 1'b0;
        ma_req   = 1'b0;
        sample();
        check("fl_ma_rvalid", {31'd0, ma_rvalid}, 32'd1);

        // Continuous contention: guard build lets fetch in on the 5th cycle.
        next_cycle();
        if_req  = 1'b1;
        if_addr = 16'h0050;
        ma_req  = 1'b1;
        ma_addr = 16'h0500;
        for (int i = 0; i < 6; i++) begin
            logic exp_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (i == 4);
`else
            exp_if = 1'b0;
`endif
            sample();
            check($sformatf("starve_ma_gnt_%0d", i), {31'd0, ma_gnt}, {31'd0, ~exp_if});
            check($sformatf("starve_if_gnt_%0d", i), {31'd0, if_gnt}, {31'd0, exp_if});
            next_cycle();
        end
        if_req = 1'b0;
        ma_req = 1'b0;
        next_cycle();

        // Reset arriving while a fetch read is in flight.
        if_req  = 1'b1;
        if_addr = 16'h0060;
        sample();
        check("rr_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle();
        rst = 1'b1;
        sample();
        check("rr_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rr_if_gnt2",   {31'd0, if_gnt},    32'd0);
        check("rr_if_stall",  {31'd0, if_stall},  32'd0);
        check("rr_mem_en",    {31'd0, mem_en},    32'd0);
        next_cycle();
        rst    = 1'b0;
        if_req = 1'b0;
        sample();
        check("rr_post_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rr_post_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter

`default_nettype wire
